// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Adds two WIDTH-bit unsigned operands one nibble per clock through a single
//   4-bit carry-select slice. A registered carry links each nibble to the next.
//   The result is assembled LSB-first by shifting each slice sum into the top of
//   the result register.
//
// Optional feature: define NIBBLE_SERIAL_ADDER_OVF_EN to add the registered
//   signed-overflow output 'ovf'.
//
// Parameters:
//   WIDTH      operand/result width, a multiple of 4 and at least 4
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operands presented
//   in_ready   block can accept operands (IDLE only)
//   a, b       unsigned operands
//   cin        carry into the least significant nibble
//   out_valid  result available, held until out_ready
//   out_ready  consumer accepts the result
//   sum        registered result
//   ovf        registered signed overflow (NIBBLE_SERIAL_ADDER_OVF_EN only)
//   cout       registered carry out of the MSB nibble
module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned CNT_W   = $clog2(NIBBLES) + 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cout_q;
    logic             in_ready_q;
    logic             out_valid_q;

    // 4-bit carry-select slice: both carry hypotheses are computed up front and
    // the registered carry picks one.
    logic [4:0]       nib_sel0;
    logic [4:0]       nib_sel1;
    logic [4:0]       nib_res_d;
    logic [WIDTH-1:0] sum_d;

    always_comb begin
        nib_sel0  = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]};
        nib_sel1  = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + 5'd1;
        nib_res_d = carry_q ? nib_sel1 : nib_sel0;
        // After WIDTH/4 shifts the first nibble lands in sum[3:0].
        sum_d     = (sum_q >> 4) | (WIDTH'(nib_res_d[3:0]) << (WIDTH - 4));
    end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // Carry into the MSB recovered from the top bits of the last nibble.
    always_comb begin
        ovf_d = (a_q[3] ^ b_q[3] ^ nib_res_d[3]) ^ nib_res_d[4];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 4;
                    b_q     <= b_q >> 4;
                    sum_q   <= sum_d;
                    carry_q <= nib_res_d[4];
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_NIB) begin
                        cout_q      <= nib_res_d[4];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                        ovf_q       <= ovf_d;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
`timescale 1ns/1ps
module tb_nibble_serial_adder;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   or_mode = 0;   // 0: out_ready high, 1: out_ready low, 2: random

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci);
        logic [WIDTH:0] full;
        exp_t           e;
        full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
        e.s  = full[WIDTH-1:0];
        e.c  = full[WIDTH];
        e.o  = (x[WIDTH-1] == y[WIDTH-1]) && (e.s[WIDTH-1] != x[WIDTH-1]);
        return e;
    endfunction

    // Scoreboard: push on accept, pop and compare on result handoff.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready)
                exp_q.push_back(model(a, b, cin));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_depth", 64'(exp_q.size()), 64'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sum", 64'(sum), 64'(mon_e.s));
                    chk("cout", 64'(cout), 64'(mon_e.c));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                    chk("ovf", 64'(ovf), 64'(mon_e.o));
`endif
                end
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic ci, input bit keep);
        int n;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = ci;
        n        = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready)
            chk("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        if (!keep)
            in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!out_valid && n < 200);
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_cout", 64'(cout), 64'd0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        chk("reset_ovf", 64'(ovf), 64'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic add and latency from the accepting edge
        send(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_valid(n);
        chk("latency", 64'(n), 64'd4);
        chk("basic_sum", 64'(sum), 64'h5555);

        // Carry ripple through every nibble
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_valid(n);
        chk("ripple1_valid", 64'(out_valid), 64'd1);
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        wait_valid(n);
        chk("ripple2_valid", 64'(out_valid), 64'd1);

        // Backpressure: result held while out_ready is low
        or_mode = 1;
        send(16'h00FF, 16'h0F01, 1'b0, 1'b0);
        wait_valid(n);
        chk("bp_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2;
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_sum", 64'(sum), 64'h1000);
            chk("bp_hold_cout", 64'(cout), 64'd0);
            chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
        end
        or_mode = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);

        // Reset two RUN clocks into an operation
        send(16'hAAAA, 16'h5555, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_sum", 64'(sum), 64'd0);
        chk("midrst_cout", 64'(cout), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_valid(n);
        chk("postrst_valid", 64'(out_valid), 64'd1);
        chk("postrst_sum", 64'(sum), 64'h0002);

        // Signed-overflow corner vectors
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_valid(n);
        send(16'h8000, 16'h8000, 1'b0, 1'b0);
        wait_valid(n);
        send(16'h0003, 16'hFFFF, 1'b0, 1'b0);
        wait_valid(n);

        // in_valid held high across three operations
        send(16'h1111, 16'h2222, 1'b0, 1'b1);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        send(16'h8001, 16'h7FFF, 1'b0, 1'b0);

        // Random vectors with random backpressure
        or_mode = 2;
        for (int k = 0; k < 1000; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
        end

        or_mode = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
